seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and iteration-counter sizing.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Counter must hold values 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude and keep or restore the remainder.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder stays below dvs, so the WIDTH+1 bit sign of diff is exact.
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Signed sequential divider: one restoring step per cycle on magnitudes,
// sign correction in FIX, fixed WIDTH+2 cycle latency from start to done.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             last;

  // Magnitudes are unsigned WIDTH-bit, so |-2^(WIDTH-1)| is representable.
  always_comb begin
    abs_a = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    abs_b = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
    last  = (cnt == CW'(WIDTH - 1));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .bit_in   (dvd_r[WIDTH-1]),
    .dvs      (dvs_r),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd_r <= abs_a;
          dvs_r <= abs_b;
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
          cnt   <= '0;
          rem_r <= '0;
          quo_r <= '0;
        end
        CALC: begin
          rem_r <= rem_nxt;
          quo_r <= {quo_r[WIDTH-2:0], q_bit};
          dvd_r <= dvd_r << 1;
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          // Zero divisor leaves |dividend| in rem_r; the sign fix restores dividend.
          if (dvs_r == '0) quotient <= '1;
          else             quotient <= neg_q ? ('0 - quo_r) : quo_r;
          remainder <= neg_r ? ('0 - rem_r) : rem_r;
          div_zero  <= (dvs_r == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start,
// checked with latency when done pulses.
module tb_seq_divider;

  localparam int unsigned W   = 8;
  localparam int          LAT = W + 2;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: integer division truncates toward zero, % takes the dividend sign.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb_;
    int ia, ib;
    sa  = W'(a);
    sb_ = W'(b);
    ia  = sa;
    ib  = sb_;
    e.cyc = 0;
    if (ib == 0) begin
      e.q  = '1;
      e.r  = W'(ia);
      e.dz = 1'b1;
    end else begin
      e.q  = W'(ia / ib);
      e.r  = W'(ia % ib);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient",  quotient,  mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_zero",  div_zero,  mon_e.dz);
        check("latency",   cyc - mon_e.cyc, LAT);
      end
    end
  end

  // Drives start for one cycle from the next falling edge; returns at cycle 1.
  task automatic issue(input int a, input int b);
    exp_t e;
    @(negedge clk);
    e     = model(a, b);
    e.cyc = cyc;
    sb.push_back(e);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < LAT + 4) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic run(input int a, input int b, input bit hold);
    exp_t e;
    e = model(a, b);
    issue(a, b);
    check("busy_cycle1", busy, 1'b1);
    wait_done();
    if (hold) begin
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_after",     busy, 1'b0);
      check("hold_quotient",  quotient,  e.q);
      check("hold_remainder", remainder, e.r);
    end
  endtask

  initial begin
    int ca[4];
    int cb[5];
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 8'h00);
    check("rst_remainder", remainder, 8'h00);
    check("rst_div_zero", div_zero, 1'b0);
    rst = 1'b0;

    run(100, 7, 1'b1);
    run(-100, 7, 1'b1);
    run(100, -7, 1'b1);
    run(-128, -1, 1'b1);
    run(5, 0, 1'b1);

    // Starts inside a running operation must be ignored.
    issue(100, 7);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd1; divisor = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd3; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);
    check("ignored_start_sb_empty", sb.size(), 0);

    // Synchronous reset during cycle 5 aborts the division.
    issue(100, 7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, 8'h00);
    check("abort_remainder", remainder, 8'h00);
    check("abort_div_zero", div_zero, 1'b0);
    repeat (15) @(negedge clk);
    run(9, 3, 1'b1);

    ca = '{-128, -1, 0, 127};
    cb = '{-128, -1, 0, 1, 127};
    foreach (ca[i]) foreach (cb[j]) run(ca[i], cb[j], 1'b0);
    for (int k = 0; k < 300; k++)
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);

    repeat (4) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
